jtdsp16_aau_gen: RTL and testbench
==================================

Name: jtdsp16_aau_gen

Overview:
Parametrised RAM address arithmetic unit for the DSP16 core and its derivatives. It holds NPTR pointer registers plus the j, k, rb and re step and limit registers, and drives the data RAM address from the selected pointer. Each instruction can post-modify that pointer. Compared with the fixed 4-pointer YAAU it adds:
- configurable data width, address width and pointer count
- bidirectional circular (modulo) buffering
- bit-reversed (FFT) post-modify mode
- a sticky wrap flag that the sequencer reads for loop diagnostics

Parameters:
DW, 16, register/data width
AW, 11, RAM address width (AW <= DW)
NPTR, 4, number of pointer registers (power of two, 2..8)
PW, $clog2(NPTR), pointer select width (derived)
RW, $clog2(NPTR+4), register select width (derived)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cen  in  1  clock enable; all state frozen when low
reg_sel  in  RW  register to load/read: 0..NPTR-1 = pointers, NPTR = j, NPTR+1 = k, NPTR+2 = rb, NPTR+3 = re
ptr_sel  in  PW  pointer used for RAM indexing and post-modify
inc_sel  in  2  unit step: 0 = -1, 1 = 0, 2 = +1, 3 = +2
step_sel  in  1  1 = use j/k step, 0 = use unit step
ksel  in  1  selects k (1) or j (0) when step_sel = 1
brev_en  in  1  bit-reversed post-modify
short_load  in  1  load sign-extended short_imm into reg_sel
long_load  in  1  load long_imm into reg_sel
acc_load  in  1  load acc into reg_sel
ram_load  in  1  load ram_dout into reg_sel
post_load  in  1  post-modify pointer ptr_sel
wrap_clr  in  1  clear wrap flag
short_imm  in  9  short immediate
long_imm  in  DW  long immediate
acc  in  DW  accumulator value
ram_dout  in  DW  RAM read data
reg_dout  out  DW  contents of register reg_sel (combinational)
ram_addr  out  AW  low AW bits of pointer ptr_sel (combinational)
wrap  out  1  sticky: set on any circular wrap

Behaviour:
- Reset (rst high on a clk edge with cen high or low) clears all pointers, j, k, rb, re and wrap to 0. reg_dout and ram_addr therefore read 0.
- All updates happen on the rising edge of clk when cen = 1. Loads and post-modify take effect the next cycle; ram_addr reflects the current pointer with zero latency.
- Load source priority: long_load > acc_load > ram_load > short_load.
- Short-immediate extension:
  - reg_sel = rb or re: zero-extended.
  - Otherwise: sign-extended from short_imm[8].
- Step value: step_sel ? (ksel ? k : j) : unit step (sign-extended to DW). Step arithmetic is modulo 2^DW.
- Circular mode is active when re != 0 and brev_en = 0. For a post-modify:
  - Step >= 0 (MSB = 0) and pointer == re: next = rb, and wrap is set.
  - Step < 0 and pointer == rb: next = re, and wrap is set.
  - Otherwise: next = pointer + step.
- Bit-reverse mode (brev_en = 1):
  - Low AW bits: next[AW-1:0] = rev(rev(p[AW-1:0]) + rev(step[AW-1:0])), carry discarded.
  - Upper DW-AW bits are unchanged.
  - Circular checks are ignored and wrap is not set.
- Simultaneous load and post-modify on the same pointer: the load wins. Post-modify on a different pointer proceeds in parallel.
- Post-modify uses the pre-edge values of j, k, rb and re, even if the same cycle loads them.
- wrap:
  - wrap_clr and a wrap event in the same cycle leave wrap = 1 (set wins).
  - wrap holds while cen = 0.
- Out-of-range reg_sel (>= NPTR+4):
  - Loads are ignored.
  - reg_dout = 0.
- reset mid-operation discards any pending load/post-modify in that cycle.

Test Plan:
- Reset with all loads active -> all registers 0, wrap = 0, ram_addr = 0.
- long_load 0x0123 into pointer 2, then ptr_sel = 2 with post_load, inc_sel = 3 over 3 cycles -> ram_addr 0x123, 0x125, 0x127, 0x129.
- Circular case: rb = 0x10 and re = 0x13 loaded via short (short_imm = 0x1F0 into rb gives 0x1F0, zero-extended). Pointer 0 = 0x12, +1 steps -> 0x13, 0x10 (wrap = 1), 0x11. Then step -1 from 0x10 -> 0x13.
- Bit-reverse with AW = 3 config, step = 4: pointer 0 -> 0, 4, 2, 6, 1, 5, 3, 7, 0. wrap stays 0.
- j = -3 via short_imm 0x1FD -> j = 0xFFFD. Same-cycle load of pointer 1 = 0x40 and post_load of pointer 1 -> pointer 1 = 0x40. Next cycle post with step_sel = 1, ksel = 0 -> 0x3D.
- cen = 0 with post_load and loads asserted -> no state change. wrap_clr together with a wrap event -> wrap remains 1. wrap_clr alone -> wrap = 0.

Source files
------------

// File: rtl/jtdsp16_aau_gen.sv
// jtdsp16_aau_gen: parametrised RAM address arithmetic unit.
// Holds NPTR pointer registers plus the j/k step and rb/re circular-limit
// registers. It drives the RAM address from the selected pointer and
// post-modifies that pointer linearly, circularly or in bit-reversed order.
// Ports:
//   clk, rst, cen         clock, sync active-high reset, clock enable
//   reg_sel               register select (pointers, then j, k, rb, re)
//   ptr_sel               pointer used for ram_addr and post-modify
//   inc_sel, step_sel,    step selection (unit step or j/k)
//   ksel, brev_en
//   *_load, post_load     load strobes and post-modify strobe
//   wrap_clr              clear the sticky wrap flag
//   short_imm, long_imm,  load sources
//   acc, ram_dout
//   reg_dout              contents of reg_sel (combinational)
//   ram_addr              low AW bits of pointer ptr_sel (combinational)
//   wrap                  sticky circular-wrap flag
module jtdsp16_aau_gen #(
    parameter int DW   = 16,
    parameter int AW   = 11,
    parameter int NPTR = 4,
    parameter int PW   = $clog2(NPTR),
    parameter int RW   = $clog2(NPTR + 4)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic [RW-1:0] reg_sel,
    input  logic [PW-1:0] ptr_sel,
    input  logic [1:0]    inc_sel,
    input  logic          step_sel,
    input  logic          ksel,
    input  logic          brev_en,
    input  logic          short_load,
    input  logic          long_load,
    input  logic          acc_load,
    input  logic          ram_load,
    input  logic          post_load,
    input  logic          wrap_clr,
    input  logic [8:0]    short_imm,
    input  logic [DW-1:0] long_imm,
    input  logic [DW-1:0] acc,
    input  logic [DW-1:0] ram_dout,
    output logic [DW-1:0] reg_dout,
    output logic [AW-1:0] ram_addr,
    output logic          wrap
);

    logic [DW-1:0] ptr [NPTR];
    logic [DW-1:0] j, k, rb, re;

    logic          sel_ptr, sel_j, sel_k, sel_rb, sel_re;
    logic          load_en, post_commit, wrap_evt;
    logic [DW-1:0] ld_val, unit, step, cur, nxt;
    logic [AW-1:0] brev_sum;

    function automatic logic [AW-1:0] rev(input logic [AW-1:0] v);
        logic [AW-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < AW; i++) r[i] = v[AW-1-i];
        return r;
    endfunction

    // register select decode
    always_comb begin
        sel_ptr = int'(reg_sel) < NPTR;
        sel_j   = int'(reg_sel) == NPTR;
        sel_k   = int'(reg_sel) == NPTR + 1;
        sel_rb  = int'(reg_sel) == NPTR + 2;
        sel_re  = int'(reg_sel) == NPTR + 3;
    end

    always_comb begin
        reg_dout = '0;
        if (sel_ptr)     reg_dout = ptr[reg_sel[PW-1:0]];
        else if (sel_j)  reg_dout = j;
        else if (sel_k)  reg_dout = k;
        else if (sel_rb) reg_dout = rb;
        else if (sel_re) reg_dout = re;
    end

    assign ram_addr = ptr[ptr_sel][AW-1:0];

    // load source mux; rb/re are unsigned limits, so short loads zero-extend
    always_comb begin
        if (long_load)               ld_val = long_imm;
        else if (acc_load)           ld_val = acc;
        else if (ram_load)           ld_val = ram_dout;
        else if (sel_rb || sel_re)   ld_val = DW'(short_imm);
        else                         ld_val = DW'($signed(short_imm));
    end

    assign load_en = (long_load | acc_load | ram_load | short_load) &
                     (sel_ptr | sel_j | sel_k | sel_rb | sel_re);

    // a load into the pointer being post-modified overrides the post-modify
    assign post_commit = post_load &
                         ~(load_en & sel_ptr & (reg_sel[PW-1:0] == ptr_sel));

    always_comb begin
        case (inc_sel)
            2'd0:    unit = '1;
            2'd1:    unit = '0;
            2'd2:    unit = DW'(1);
            default: unit = DW'(2);
        endcase
        step = step_sel ? (ksel ? k : j) : unit;
    end

    always_comb begin
        cur      = ptr[ptr_sel];
        brev_sum = rev(rev(cur[AW-1:0]) + rev(step[AW-1:0]));
        wrap_evt = 1'b0;
        nxt      = cur + step;
        if (brev_en) begin
            nxt           = cur;
            nxt[AW-1:0]   = brev_sum;
        end else if (re != '0) begin
            if (!step[DW-1] && cur == re) begin
                nxt      = rb;
                wrap_evt = 1'b1;
            end else if (step[DW-1] && cur == rb) begin
                nxt      = re;
                wrap_evt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NPTR; i++) ptr[i] <= '0;
            j    <= '0;
            k    <= '0;
            rb   <= '0;
            re   <= '0;
            wrap <= 1'b0;
        end else if (cen) begin
            if (post_commit) ptr[ptr_sel] <= nxt;
            if (load_en) begin
                if (sel_ptr)     ptr[reg_sel[PW-1:0]] <= ld_val;
                else if (sel_j)  j  <= ld_val;
                else if (sel_k)  k  <= ld_val;
                else if (sel_rb) rb <= ld_val;
                else if (sel_re) re <= ld_val;
            end
            // set has priority over clear
            if (post_commit && wrap_evt) wrap <= 1'b1;
            else if (wrap_clr)           wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jtdsp16_aau_gen.sv
module tb_jtdsp16_aau_gen;

    logic        clk = 1'b0;
    logic        rst, cen;
    logic [2:0]  reg_sel;
    logic [1:0]  ptr_sel, inc_sel;
    logic        step_sel, ksel, brev_en;
    logic        short_load, long_load, acc_load, ram_load, post_load, wrap_clr;
    logic [8:0]  short_imm;
    logic [15:0] long_imm, acc, ram_dout;
    logic [15:0] reg_dout, reg_dout2;
    logic [10:0] ram_addr;
    logic [2:0]  ram_addr2;
    logic        wrap, wrap2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    jtdsp16_aau_gen dut (
        .clk(clk), .rst(rst), .cen(cen), .reg_sel(reg_sel), .ptr_sel(ptr_sel),
        .inc_sel(inc_sel), .step_sel(step_sel), .ksel(ksel), .brev_en(brev_en),
        .short_load(short_load), .long_load(long_load), .acc_load(acc_load),
        .ram_load(ram_load), .post_load(post_load), .wrap_clr(wrap_clr),
        .short_imm(short_imm), .long_imm(long_imm), .acc(acc), .ram_dout(ram_dout),
        .reg_dout(reg_dout), .ram_addr(ram_addr), .wrap(wrap)
    );

    // narrow-address instance for bit-reverse checks (shares all inputs)
    jtdsp16_aau_gen #(.AW(3)) dut2 (
        .clk(clk), .rst(rst), .cen(cen), .reg_sel(reg_sel), .ptr_sel(ptr_sel),
        .inc_sel(inc_sel), .step_sel(step_sel), .ksel(ksel), .brev_en(brev_en),
        .short_load(short_load), .long_load(long_load), .acc_load(acc_load),
        .ram_load(ram_load), .post_load(post_load), .wrap_clr(wrap_clr),
        .short_imm(short_imm), .long_imm(long_imm), .acc(acc), .ram_dout(ram_dout),
        .reg_dout(reg_dout2), .ram_addr(ram_addr2), .wrap(wrap2)
    );

    task automatic idle();
        rst = 0; cen = 1; reg_sel = 0; ptr_sel = 0; inc_sel = 1;
        step_sel = 0; ksel = 0; brev_en = 0;
        short_load = 0; long_load = 0; acc_load = 0; ram_load = 0;
        post_load = 0; wrap_clr = 0;
        short_imm = 0; long_imm = 0; acc = 0; ram_dout = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1; long_load = 1; acc_load = 1; ram_load = 1; short_load = 1;
        post_load = 1; inc_sel = 3; long_imm = 16'hBEEF; reg_sel = 2;
        tick();
        idle();
        for (int i = 0; i < 8; i++) begin
            reg_sel = 3'(i);
            #1;
            tests++;
            if (reg_dout !== 16'h0) begin
                fails++;
                $display("FAIL reset_reg%0d got %h want 0000", i, reg_dout);
            end
        end
        tests++;
        if (ram_addr !== 11'h0) begin
            fails++; $display("FAIL reset_ram_addr got %h want 000", ram_addr);
        end
        tests++;
        if (wrap !== 1'b0) begin
            fails++; $display("FAIL reset_wrap got %b want 0", wrap);
        end
    endtask

    task automatic test_post_inc();
        logic [10:0] exp_a [4] = '{11'h123, 11'h125, 11'h127, 11'h129};
        idle();
        long_load = 1; reg_sel = 2; long_imm = 16'h0123;
        tick();
        idle();
        ptr_sel = 2;
        #1;
        tests++;
        if (ram_addr !== exp_a[0]) begin
            fails++; $display("FAIL inc_start got %h want %h", ram_addr, exp_a[0]);
        end
        post_load = 1; inc_sel = 3;
        for (int i = 1; i < 4; i++) begin
            tick();
            tests++;
            if (ram_addr !== exp_a[i]) begin
                fails++; $display("FAIL inc_step%0d got %h want %h", i, ram_addr, exp_a[i]);
            end
        end
        idle();
    endtask

    task automatic test_circular();
        logic [15:0] exp_p [5] = '{16'h0013, 16'h0010, 16'h0011, 16'h0010, 16'h0013};
        logic        exp_w [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        idle();
        short_load = 1; reg_sel = 6; short_imm = 9'h1F0;
        tick();
        short_load = 0;
        #1;
        tests++;
        if (reg_dout !== 16'h01F0) begin
            fails++; $display("FAIL rb_zero_ext got %h want 01f0", reg_dout);
        end
        short_load = 1; reg_sel = 0; short_imm = 9'h1F0;
        tick();
        short_load = 0;
        #1;
        tests++;
        if (reg_dout !== 16'hFFF0) begin
            fails++; $display("FAIL ptr_sign_ext got %h want fff0", reg_dout);
        end
        short_load = 1;
        reg_sel = 6; short_imm = 9'h010; tick();
        reg_sel = 7; short_imm = 9'h013; tick();
        reg_sel = 0; short_imm = 9'h012; tick();
        idle();
        post_load = 1; ptr_sel = 0;
        for (int i = 0; i < 5; i++) begin
            inc_sel = (i < 3) ? 2'd2 : 2'd0;
            tick();
            tests++;
            if (ram_addr !== exp_p[i][10:0] || wrap !== exp_w[i]) begin
                fails++;
                $display("FAIL circ_step%0d got addr %h wrap %b want %h %b",
                         i, ram_addr, wrap, exp_p[i][10:0], exp_w[i]);
            end
        end
        idle();
        wrap_clr = 1;
        tick();
        idle();
        tests++;
        if (wrap !== 1'b0) begin
            fails++; $display("FAIL circ_clr got %b want 0", wrap);
        end
    endtask

    task automatic test_brev();
        logic [2:0] exp_b [8] = '{3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7, 3'd0};
        idle();
        short_load = 1; reg_sel = 4; short_imm = 9'd4;
        tick();
        short_load = 0; long_load = 1; reg_sel = 0; long_imm = 16'h1230;
        tick();
        idle();
        post_load = 1; brev_en = 1; step_sel = 1; ksel = 0; ptr_sel = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            tests++;
            if (ram_addr2 !== exp_b[i]) begin
                fails++; $display("FAIL brev_step%0d got %0d want %0d", i, ram_addr2, exp_b[i]);
            end
            if (i == 0) begin
                tests++;
                if (reg_dout2 !== 16'h1234) begin
                    fails++; $display("FAIL brev_upper got %h want 1234", reg_dout2);
                end
            end
        end
        idle();
        #1;
        tests++;
        if (reg_dout2 !== 16'h1230 || wrap2 !== 1'b0) begin
            fails++; $display("FAIL brev_end got %h wrap %b want 1230 0", reg_dout2, wrap2);
        end
    endtask

    task automatic test_same_cycle();
        idle();
        short_load = 1; reg_sel = 4; short_imm = 9'h1FD;
        tick();
        short_load = 0;
        #1;
        tests++;
        if (reg_dout !== 16'hFFFD) begin
            fails++; $display("FAIL j_sign_ext got %h want fffd", reg_dout);
        end
        long_load = 1; reg_sel = 1; long_imm = 16'h0040;
        post_load = 1; ptr_sel = 1; inc_sel = 2;
        tick();
        idle();
        ptr_sel = 1;
        #1;
        tests++;
        if (ram_addr !== 11'h040) begin
            fails++; $display("FAIL load_wins got %h want 040", ram_addr);
        end
        post_load = 1; step_sel = 1; ksel = 0;
        tick();
        tests++;
        if (ram_addr !== 11'h03D) begin
            fails++; $display("FAIL j_step got %h want 03d", ram_addr);
        end
        // load j while stepping by j: the old j (-3) must be used
        long_load = 1; reg_sel = 4; long_imm = 16'h0005;
        tick();
        long_load = 0;
        #1;
        tests++;
        if (ram_addr !== 11'h03A || reg_dout !== 16'h0005) begin
            fails++; $display("FAIL pre_edge_j got %h j %h want 03a 0005", ram_addr, reg_dout);
        end
        long_load = 1; reg_sel = 3; long_imm = 16'h0077;
        tick();
        long_load = 0;
        #1;
        tests++;
        if (ram_addr !== 11'h03F || reg_dout !== 16'h0077) begin
            fails++; $display("FAIL parallel got %h p3 %h want 03f 0077", ram_addr, reg_dout);
        end
        idle();
    endtask

    task automatic test_cen_wrap();
        idle();
        long_load = 1; reg_sel = 0; long_imm = 16'h0013;
        tick();
        idle();
        cen = 0; post_load = 1; ptr_sel = 0; inc_sel = 2;
        long_load = 1; reg_sel = 1; long_imm = 16'hAAAA; wrap_clr = 1;
        tick();
        long_load = 0;
        #1;
        tests++;
        if (ram_addr !== 11'h013 || reg_dout !== 16'h003F || wrap !== 1'b0) begin
            fails++;
            $display("FAIL cen_freeze got %h p1 %h wrap %b want 013 003f 0",
                     ram_addr, reg_dout, wrap);
        end
        cen = 1;
        tick();
        tests++;
        if (ram_addr !== 11'h010 || wrap !== 1'b1) begin
            fails++; $display("FAIL set_beats_clr got %h wrap %b want 010 1", ram_addr, wrap);
        end
        idle();
        cen = 0; wrap_clr = 1;
        tick();
        tests++;
        if (wrap !== 1'b1) begin
            fails++; $display("FAIL wrap_hold got %b want 1", wrap);
        end
        cen = 1;
        tick();
        tests++;
        if (wrap !== 1'b0) begin
            fails++; $display("FAIL wrap_clr got %b want 0", wrap);
        end
        idle();
    endtask

    task automatic test_reset_cen_low();
        idle();
        rst = 1; cen = 0; post_load = 1; inc_sel = 2;
        tick();
        idle();
        reg_sel = 1;
        #1;
        tests++;
        if (reg_dout !== 16'h0 || ram_addr !== 11'h0) begin
            fails++; $display("FAIL reset_cen0 got %h addr %h want 0000 000", reg_dout, ram_addr);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_post_inc();
        test_circular();
        test_brev();
        test_same_cycle();
        test_cen_wrap();
        test_reset_cen_low();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
